// File: rtl/lcd_cfah_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_cfah_pkg : shared types, init ROM and delay helpers for lcd_cfah_ctrl  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package lcd_cfah_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT   = 3'd0,
        INIT_ISSUE = 3'd1,
        ISSUE_WAIT = 3'd2,
        POST_WAIT  = 3'd3,
        READY      = 3'd4
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
        ,
        POLL_ISSUE = 3'd5,
        POLL_WAIT  = 3'd6
`endif
    } state_t;

    // Entry 0 is sent first.
    localparam logic [3:0][7:0] c_init_rom = {8'h06, 8'h01, 8'h0C, 8'h38};
    localparam int c_busy_bit = 7;
    localparam int c_dly_w    = 32;

    function automatic logic [c_dly_w-1:0] f_us_to_cycles(input int us, input int period_ns);
        longint n;
        n = (longint'(us) * 1000 + longint'(period_ns) - 1) / longint'(period_ns);
        if (n < 1) n = 1;
        return n[c_dly_w-1:0];
    endfunction

    // Clear display / return home need the long settle time.
    function automatic logic f_is_clear(input logic rs, input logic [7:0] d);
        return !rs && (d >= 8'h01) && (d <= 8'h03);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cfah_delay_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_cfah_delay_cnt : loadable down-counter, one-cycle done after N cycles  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lcd_cfah_delay_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_value,
    output logic         o_done,
    output logic         o_busy
);

    logic [W-1:0] r_cnt;
    logic         r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= i_value;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_cnt <= r_cnt - W'(1);
            if (r_cnt == W'(1)) r_busy <= 1'b0;
        end
    end

    assign o_done = r_busy && (r_cnt == W'(1));
    assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/lcd_cfah_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_cfah_ctrl : power-up/init sequencer and command front end for the LCD  |
// | bus interface. Define LCD_CFAH_CTRL_BUSY_POLL_EN for busy-flag completion. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lcd_cfah_ctrl
    import lcd_cfah_pkg::*;
#(
    parameter int G_CLK_PERIOD_NS = 20,
    parameter int G_PWR_UP_US     = 40000,
    parameter int G_CMD_WAIT_US   = 40,
    parameter int G_CLR_WAIT_US   = 1640,
    parameter int G_POLL_MAX      = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    output logic       o_init_done,
    output logic       o_err,
    output logic [7:0] o_itf_wdata,
    output logic       o_itf_rs,
    output logic       o_itf_rw,
    output logic       o_itf_start,
    input  logic       i_itf_done,
    input  logic [7:0] i_itf_rdata
);

    localparam logic [c_dly_w-1:0] c_pwr_cycles = f_us_to_cycles(G_PWR_UP_US, G_CLK_PERIOD_NS);
    localparam logic [c_dly_w-1:0] c_cmd_cycles = f_us_to_cycles(G_CMD_WAIT_US, G_CLK_PERIOD_NS);
    localparam logic [c_dly_w-1:0] c_clr_cycles = f_us_to_cycles(G_CLR_WAIT_US, G_CLK_PERIOD_NS);

    state_t             r_state, w_next, w_after;
    logic [1:0]         r_rom_idx;
    logic               r_initing;
    logic               r_itf_start, r_itf_rs, r_itf_rw, r_cmd_ready, r_init_done, r_err;
    logic [7:0]         r_itf_wdata;
    logic               w_start_n, w_rs_n, w_rw_n, w_ready_n, w_init_done_n, w_err_n;
    logic [7:0]         w_wdata_n;
    logic               w_dly_start, w_dly_done, w_dly_busy;
    logic [c_dly_w-1:0] w_dly_value;
    logic               w_accept, w_use_poll, w_complete, w_init_last;
    logic               w_unused_rdata;

    assign w_unused_rdata = ^i_itf_rdata;
    assign w_accept       = (r_state == READY) && i_cmd_valid;
    assign w_init_last    = r_initing && (r_rom_idx == 2'd3);
    assign w_after        = (r_initing && !w_init_last) ? INIT_ISSUE : READY;

`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
    localparam int c_poll_w = $clog2(G_POLL_MAX + 1);
    logic [c_poll_w-1:0] r_poll_cnt;
    logic                w_poll_last, w_poll_again;

    assign w_poll_last  = (int'(r_poll_cnt) + 1) >= G_POLL_MAX;
    assign w_poll_again = i_itf_rdata[c_busy_bit] && !w_poll_last;
    // The first init word goes out before the busy flag is trustworthy.
    assign w_use_poll   = !(r_initing && (r_rom_idx == 2'd0));
    assign w_complete   = ((r_state == POST_WAIT) && w_dly_done) ||
                          ((r_state == POLL_WAIT) && i_itf_done && !w_poll_again);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_poll_cnt <= '0;
        else if (r_state == ISSUE_WAIT)               r_poll_cnt <= '0;
        else if ((r_state == POLL_WAIT) && i_itf_done) r_poll_cnt <= r_poll_cnt + c_poll_w'(1);
    end
`else
    assign w_use_poll = 1'b0;
    assign w_complete = (r_state == POST_WAIT) && w_dly_done;
`endif

    assign w_dly_start = ((r_state == PWR_WAIT) && !w_dly_busy) ||
                         ((r_state == ISSUE_WAIT) && i_itf_done && !w_use_poll);
    assign w_dly_value = (r_state == PWR_WAIT) ? c_pwr_cycles :
                         f_is_clear(r_itf_rs, r_itf_wdata) ? c_clr_cycles : c_cmd_cycles;

    lcd_cfah_delay_cnt #(
        .W (c_dly_w)
    ) u_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_dly_start),
        .i_value (w_dly_value),
        .o_done  (w_dly_done),
        .o_busy  (w_dly_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PWR_WAIT;
            r_rom_idx   <= 2'd0;
            r_initing   <= 1'b1;
            r_itf_start <= 1'b0;
            r_itf_wdata <= 8'h00;
            r_itf_rs    <= 1'b0;
            r_itf_rw    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_itf_start <= w_start_n;
            r_itf_wdata <= w_wdata_n;
            r_itf_rs    <= w_rs_n;
            r_itf_rw    <= w_rw_n;
            r_cmd_ready <= w_ready_n;
            r_init_done <= w_init_done_n;
            r_err       <= w_err_n;
            if (w_complete) begin
                if (w_init_last)    r_initing <= 1'b0;
                else if (r_initing) r_rom_idx <= r_rom_idx + 2'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            PWR_WAIT:   if (w_dly_done) w_next = INIT_ISSUE;
            INIT_ISSUE: w_next = ISSUE_WAIT;
            ISSUE_WAIT: if (i_itf_done) begin
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
                w_next = w_use_poll ? POLL_ISSUE : POST_WAIT;
`else
                w_next = POST_WAIT;
`endif
            end
            POST_WAIT:  if (w_dly_done) w_next = w_after;
            READY:      if (w_accept) w_next = ISSUE_WAIT;
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
            POLL_ISSUE: w_next = POLL_WAIT;
            POLL_WAIT:  if (i_itf_done) w_next = w_poll_again ? POLL_ISSUE : w_after;
`endif
            default:    w_next = PWR_WAIT;
        endcase
    end

    // Bus fields are only reloaded when a transfer launches, so they stay put until done.
    always_comb begin
        w_start_n     = 1'b0;
        w_wdata_n     = r_itf_wdata;
        w_rs_n        = r_itf_rs;
        w_rw_n        = r_itf_rw;
        w_ready_n     = (w_next == READY);
        w_init_done_n = r_init_done || (w_next == READY);
        w_err_n       = r_err;
        if (r_state == INIT_ISSUE) begin
            w_start_n = 1'b1;
            w_wdata_n = c_init_rom[r_rom_idx];
            w_rs_n    = 1'b0;
            w_rw_n    = 1'b0;
        end
        if (w_accept) begin
            w_start_n = 1'b1;
            w_wdata_n = i_cmd_data;
            w_rs_n    = i_cmd_rs;
            w_rw_n    = 1'b0;
        end
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
        if (r_state == POLL_ISSUE) begin
            w_start_n = 1'b1;
            w_wdata_n = 8'h00;
            w_rs_n    = 1'b0;
            w_rw_n    = 1'b1;
        end
        if ((r_state == POLL_WAIT) && i_itf_done && i_itf_rdata[c_busy_bit] && w_poll_last)
            w_err_n = 1'b1;
`endif
    end

    assign o_itf_start = r_itf_start;
    assign o_itf_wdata = r_itf_wdata;
    assign o_itf_rs    = r_itf_rs;
    assign o_itf_rw    = r_itf_rw;
    assign o_cmd_ready = r_cmd_ready;
    assign o_init_done = r_init_done;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: doc/lcd_cfah_ctrl.md
LCD_CFAH_CTRL -- requirements
Module: lcd_cfah_ctrl

Interface
REQ-001 SHALL have parameter G_CLK_PERIOD_NS, default 20, clock period in ns for delay computation.
REQ-002 SHALL have parameter G_PWR_UP_US, default 40000, power-up wait before first init command.
REQ-003 SHALL have parameter G_CMD_WAIT_US, default 40, post-command wait for ordinary commands and data.
REQ-004 SHALL have parameter G_CLR_WAIT_US, default 1640, post-command wait for clear/home (RS=0, data 0x01..0x03).
REQ-005 SHALL have parameter G_POLL_MAX, default 255, maximum busy-flag reads before timeout.
REQ-006 SHALL have ports clk in 1, system clock; rst_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports i_cmd_valid in 1, request valid; i_cmd_rs in 1, 0=instruction 1=data; i_cmd_data in 8, byte to write.
REQ-008 SHALL have ports o_cmd_ready out 1, request accepted when high with valid; o_init_done out 1, init sequence complete; o_err out 1, sticky poll timeout.
REQ-009 SHALL have ports o_itf_wdata out 8, o_itf_rs out 1, o_itf_rw out 1, o_itf_start out 1, to lcd_cfah_itf i_wdata/i_rs/i_rw/i_start.
REQ-010 SHALL have ports i_itf_done in 1, i_itf_rdata in 8, from lcd_cfah_itf o_done/o_lcd_rdata.

Function
REQ-011 SHALL implement FSM states PWR_WAIT, INIT_ISSUE, ISSUE_WAIT, POST_WAIT, READY, POLL_ISSUE, POLL_WAIT.
REQ-012 SHALL, after reset, count G_PWR_UP_US*1000/G_CLK_PERIOD_NS cycles in PWR_WAIT, then go to INIT_ISSUE.
REQ-013 SHALL issue init ROM in order: 0x38, 0x0C, 0x01, 0x06 (all RS=0, RW=0), each followed by its post-command completion phase.
REQ-014 SHALL pulse o_itf_start high exactly one cycle per transfer; hold o_itf_wdata/rs/rw stable from that cycle until i_itf_done is sampled high.
REQ-015 SHALL ignore i_itf_done outside ISSUE_WAIT and POLL_WAIT.
REQ-016 SHALL assert o_init_done the cycle READY is first entered and keep it high until reset.
REQ-017 SHALL drive o_cmd_ready high only in READY; transfer accepted when i_cmd_valid and o_cmd_ready both high on a rising edge.
REQ-018 SHALL deassert o_cmd_ready the cycle after acceptance and start the transfer (o_itf_start) on that same cycle.
REQ-019 SHALL leave i_cmd_valid requests presented during init or busy pending (not dropped, not accepted) until READY.
REQ-020 SHALL select G_CLR_WAIT_US when RS=0 and data in 0x01..0x03, else G_CMD_WAIT_US, for delay-mode completion.
REQ-021 SHALL compute delays with ceiling division; a computed count of 0 SHALL be forced to 1.
REQ-022 SHALL, in poll mode, issue reads RS=0 RW=1; busy when i_itf_rdata[7]=1; reissue until bit7=0.
REQ-023 SHALL, after G_POLL_MAX busy reads, set o_err (sticky) and proceed as if not busy.
REQ-024 SHALL use delay completion (not polling) for the first init command 0x38 in both modes.

Reset
REQ-025 SHALL asynchronously on rst_n low force state PWR_WAIT, counters 0, o_itf_start 0, o_itf_wdata 0x00, o_itf_rs 0, o_itf_rw 0, o_cmd_ready 0, o_init_done 0, o_err 0.
REQ-026 SHALL, on reset asserted mid-transfer, abandon the transfer and restart the full power-up and init sequence after release.

Configuration
REQ-027 SHALL, with LCD_CFAH_CTRL_BUSY_POLL_EN defined, use POLL_ISSUE/POLL_WAIT for post-command completion (except REQ-024).
REQ-028 SHALL, without LCD_CFAH_CTRL_BUSY_POLL_EN, use POST_WAIT fixed delays only, never drive o_itf_rw=1, hold o_err at 0, and not compile poll states.

Structure
REQ-029 SHALL place state enum, init ROM constants (0x38,0x0C,0x01,0x06) and busy bit index in package lcd_cfah_pkg.
REQ-030 SHALL use one sub-module lcd_cfah_delay_cnt (load value, start, done pulse) for PWR_WAIT and POST_WAIT.

Verification
REQ-031 Reset release, G_PWR_UP_US=1, 20 ns clk -> no o_itf_start for 50 cycles, then writes 0x38,0x0C,0x01,0x06 in order, o_init_done high after the last completion.
REQ-032 Delay mode, after init: data 'A' (rs=1, 0x41) -> one start pulse, wdata 0x41 rs 1 rw 0, next o_cmd_ready >= 2000 cycles later at 20 ns; 0x01 rs 0 -> >= 82000 cycles.
REQ-033 Poll mode, emulator returns 0x80 twice then 0x00 -> exactly three reads (rw=1) after write, then o_cmd_ready high.
REQ-034 Poll mode, emulator always 0x80, G_POLL_MAX=4 -> four reads, o_err rises and stays 1, controller returns to READY.
REQ-035 i_cmd_valid held high from reset with 0x42 rs=1 -> accepted only after o_init_done, exactly once per valid-ready cycle.
REQ-036 rst_n low during ISSUE_WAIT of init command 0x01 -> all outputs at reset values immediately; after release full sequence restarts from 0x38.
